// File: rtl/complex_pkg.sv
// -----------------------------------------------------------------------------
// complex_pkg
// Types and helpers shared by the FFT datapath blocks: the complex sample
// type, the stage sequencer state encoding, and helpers that size the
// read-to-write pipeline (one memory read cycle plus the butterfly depth).
// No ports; imported by the sequencer, the butterfly and the memory wrapper.
// -----------------------------------------------------------------------------
package complex_pkg;

    localparam int CPLX_W = 16;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // Read-to-write distance: one cycle of synchronous memory read followed
    // by the butterfly pipeline.
    function automatic int pipe_depth(input int bf_latency);
        return 1 + bf_latency;
    endfunction

    // Width of a counter that must hold values 0..n-1 (never less than 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fft_wr_delay.sv
// -----------------------------------------------------------------------------
// fft_wr_delay
// Fixed-depth shift register that turns a read strobe/address bundle into the
// matching write strobe/address bundle DEPTH cycles later.
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset, empties the line
//   flush in   synchronous clear of every stage (drops pending writes)
//   din   in   WIDTH-bit bundle entering the line
//   dout  out  WIDTH-bit bundle leaving the line, DEPTH cycles after din
// -----------------------------------------------------------------------------
module fft_wr_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] line_q [DEPTH];

    // NOTE: every stage carries a live write strobe, so this small array is
    // reset like ordinary flops; a RAM-style store would not be.
    // NOTE: non-blocking assignments make each stage take the value its
    // neighbour held before the edge, which is what a shift register is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else begin
            line_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
        end
    end

    assign dout = line_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// fft_stage_sequencer
// In-place radix-2 DIT FFT control: walks N_LOG2 stages of N/2 butterflies,
// issuing operand reads and (PIPE cycles later) result writes.
//   clk, rst              clock, asynchronous active-high reset
//   start                 begin a transform (ignored while busy / in done cycle)
//   abort                 cancel a running transform, dropping pending writes
//   busy                  transform in progress (ISSUE or DRAIN)
//   done                  one-cycle pulse after the last write of the last stage
//   stage                 current stage index
//   rd_en, rd_addr_a/b    operand read strobe and top/bottom addresses
//   tw_addr               twiddle ROM address, valid with rd_en
//   wr_en, wr_addr_a/b    result write strobe and addresses
// -----------------------------------------------------------------------------
module fft_stage_sequencer
    import complex_pkg::*;
#(
    parameter int N_LOG2     = 9,
    parameter int BF_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(N_LOG2)-1:0] stage,
    output logic                      rd_en,
    output logic [N_LOG2-1:0]         rd_addr_a,
    output logic [N_LOG2-1:0]         rd_addr_b,
    output logic [N_LOG2-2:0]         tw_addr,
    output logic                      wr_en,
    output logic [N_LOG2-1:0]         wr_addr_a,
    output logic [N_LOG2-1:0]         wr_addr_b
);

    localparam int PIPE = pipe_depth(BF_LATENCY);
    localparam int SW   = $clog2(N_LOG2);
    localparam int KW   = N_LOG2 - 1;
    localparam int DCW  = cnt_width(PIPE);
    localparam int DLW  = 2 * N_LOG2 + 1;

    localparam logic [KW-1:0]  K_LAST = '1;
    localparam logic [SW-1:0]  S_LAST = SW'(N_LOG2 - 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(PIPE - 1);

    seq_state_t        state, state_nxt;
    logic [KW-1:0]     k;
    logic [SW-1:0]     stage_q;
    logic [DCW-1:0]    dcnt;
    logic              done_q;
    logic              k_last, s_last, d_last, accept;

    int                s_i;
    logic [N_LOG2-1:0] k_ext, pos, addr_a, addr_b;
    logic [KW-1:0]     addr_tw;
    logic [DLW-1:0]    dly_out;

    assign k_last = (k == K_LAST);
    assign s_last = (stage_q == S_LAST);
    assign d_last = (dcnt == D_LAST);
    // A start landing in the done cycle is dropped; abort beats start.
    assign accept = start && !abort && !done_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    // NOTE: defaulting every always_comb output first keeps paths that do not
    // assign it from inferring a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = ISSUE;
            ISSUE: begin
                if (abort)       state_nxt = IDLE;
                else if (k_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort)       state_nxt = IDLE;
                else if (d_last) state_nxt = s_last ? IDLE : ISSUE;
            end
            default:             state_nxt = IDLE;
        endcase
    end

    // Butterfly, stage and drain counters plus the registered done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= '0;
            stage_q <= '0;
            dcnt    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == DRAIN) && d_last && s_last && !abort;
            if (abort || state == IDLE) begin
                k       <= '0;
                stage_q <= '0;
                dcnt    <= '0;
            end else if (state == ISSUE) begin
                k    <= k_last ? '0 : k + 1'b1;
                dcnt <= '0;
            end else if (d_last) begin
                dcnt    <= '0;
                stage_q <= s_last ? '0 : stage_q + 1'b1;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    // Address generator: butterfly k of stage s pairs a and a+2^s, where a
    // keeps the low s bits of k and opens a zero at bit s.
    always_comb begin
        s_i     = int'(stage_q);
        k_ext   = {1'b0, k};
        pos     = k_ext & N_LOG2'((1 << s_i) - 1);
        addr_a  = ((k_ext >> s_i) << (s_i + 1)) | pos;
        addr_b  = addr_a | N_LOG2'(1 << s_i);
        addr_tw = KW'(pos << (N_LOG2 - 1 - s_i));
    end

    // Outputs; addresses are held at zero whenever no read is issued.
    always_comb begin
        busy      = (state != IDLE);
        done      = done_q;
        stage     = stage_q;
        rd_en     = (state == ISSUE);
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_addr   = '0;
        if (state == ISSUE) begin
            rd_addr_a = addr_a;
            rd_addr_b = addr_b;
            tw_addr   = addr_tw;
        end
    end

    fft_wr_delay #(
        .DEPTH (PIPE),
        .WIDTH (DLW)
    ) u_wr_delay (
        .clk   (clk),
        .rst   (rst),
        .flush (abort && busy),
        .din   ({rd_en, rd_addr_a, rd_addr_b}),
        .dout  (dly_out)
    );

    assign {wr_en, wr_addr_a, wr_addr_b} = dly_out;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_stage_sequencer
// Scoreboard bench for an 8-point (N_LOG2=3, BF_LATENCY=2) sequencer. Each
// accepted start pushes the expected reads, writes and done cycle; a monitor
// on the falling edge pops and compares as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_fft_stage_sequencer;

    localparam int NL    = 3;
    localparam int BFL   = 2;
    localparam int PIPE  = BFL + 1;
    localparam int N     = 1 << NL;
    localparam int RUN   = NL * (N / 2 + PIPE) + 1;
    localparam int NEVER = 1 << 30;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, rd_en, wr_en;
    logic [1:0]    stage;
    logic [NL-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [NL-2:0] tw_addr;

    fft_stage_sequencer #(
        .N_LOG2     (NL),
        .BF_LATENCY (BFL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int cyc;
        int s;
        int a;
        int b;
        int tw;
    } xact_t;

    xact_t rd_q[$];
    xact_t wr_q[$];
    int    done_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected traffic of a transform started in cycle c0. Anything at or
    // after cycle 'cut' (abort+1 or reset cycle) never happens.
    task automatic push_run(input int c0, input int cut);
        int    idx;
        int    half;
        xact_t x;
        for (int s = 0; s < NL; s++) begin
            half = 1 << s;
            idx  = 0;
            for (int g = 0; g < N; g += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    x.cyc = c0 + 1 + s * (N / 2 + PIPE) + idx;
                    x.s   = s;
                    x.a   = g + j;
                    x.b   = g + j + half;
                    x.tw  = j * ((N / 2) / half);
                    if (x.cyc < cut) rd_q.push_back(x);
                    x.cyc = x.cyc + PIPE;
                    if (x.cyc < cut) wr_q.push_back(x);
                    idx++;
                end
            end
        end
        if (cut == NEVER) done_q.push_back(c0 + RUN);
    endtask

    always @(negedge clk) begin
        xact_t e;
        if (!rst) begin
            if (rd_en) begin
                if (rd_q.size() == 0) check("rd_unexpected", cyc, -1);
                else begin
                    e = rd_q.pop_front();
                    check("rd_cycle", cyc, e.cyc);
                    check("rd_stage", int'(stage), e.s);
                    check("rd_addr_a", int'(rd_addr_a), e.a);
                    check("rd_addr_b", int'(rd_addr_b), e.b);
                    check("tw_addr", int'(tw_addr), e.tw);
                end
            end
            if (wr_en) begin
                if (wr_q.size() == 0) check("wr_unexpected", cyc, -1);
                else begin
                    e = wr_q.pop_front();
                    check("wr_cycle", cyc, e.cyc);
                    check("wr_addr_a", int'(wr_addr_a), e.a);
                    check("wr_addr_b", int'(wr_addr_b), e.b);
                end
            end
            if (done) begin
                check("done_with_busy", int'(busy), 0);
                if (done_q.size() == 0) check("done_unexpected", cyc, -1);
                else check("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_rd_left"}, rd_q.size(), 0);
        check({tag, "_wr_left"}, wr_q.size(), 0);
        check({tag, "_done_left"}, done_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_rd_en"}, int'(rd_en), 0);
        check({tag, "_wr_en"}, int'(wr_en), 0);
        check({tag, "_rd_addr_a"}, int'(rd_addr_a), 0);
        check({tag, "_rd_addr_b"}, int'(rd_addr_b), 0);
        check({tag, "_tw_addr"}, int'(tw_addr), 0);
        check({tag, "_wr_addr_a"}, int'(wr_addr_a), 0);
        check({tag, "_wr_addr_b"}, int'(wr_addr_b), 0);
        check({tag, "_stage"}, int'(stage), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        int c0;

        // Reset values
        #2;
        check_all_zero("reset");
        step();
        step();
        rst = 1'b0;
        step();
        step();

        // Full transform: reads 1-4, 8-11, 15-18; writes PIPE later; done at 22
        c0    = cyc;
        start = 1'b1;
        push_run(c0, NEVER);
        step();
        start = 1'b0;
        go_to(c0 + 2);
        check("busy_in_run", int'(busy), 1);
        go_to(c0 + RUN);
        check("busy_at_done", int'(busy), 0);
        go_to(c0 + RUN + 3);
        check_drained("run");

        // Abort in cycle 9 of stage 1, restart at cycle 12, done at 34
        c0    = cyc;
        start = 1'b1;
        push_run(c0, c0 + 10);
        step();
        start = 1'b0;
        go_to(c0 + 9);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle", int'(busy), 0);
        go_to(c0 + 12);
        check_drained("abort");
        start = 1'b1;
        push_run(c0 + 12, NEVER);
        step();
        start = 1'b0;
        go_to(c0 + 12 + RUN + 3);
        check_drained("restart");

        // Abort and start together in IDLE: stays idle
        c0    = cyc;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_idle", int'(busy), 0);
        go_to(c0 + 6);
        check_drained("abort_start");

        // Start held high: ignored while busy and in the done cycle,
        // accepted the cycle after done.
        c0    = cyc;
        start = 1'b1;
        push_run(c0, NEVER);
        push_run(c0 + RUN + 1, NEVER);
        go_to(c0 + RUN);
        check("held_done_cycle_busy", int'(busy), 0);
        go_to(c0 + RUN + 1);
        step();
        start = 1'b0;
        check("held_second_run_busy", int'(busy), 1);
        go_to(c0 + 2 * RUN + 1 + 3);
        check_drained("held");

        // Reset at cycle 5, while the first writes are in flight
        c0    = cyc;
        start = 1'b1;
        push_run(c0, c0 + 5);
        step();
        start = 1'b0;
        go_to(c0 + 5);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        go_to(c0 + 7);
        rst = 1'b0;
        go_to(c0 + 30);
        check("post_reset_busy", int'(busy), 0);
        check_drained("mid_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter N_LOG2, default 9, meaning log2 of FFT points (N = 2^N_LOG2, range 2..12).
REQ-002 SHALL have parameter BF_LATENCY, default 2, meaning butterfly pipeline depth in cycles.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  begin a transform; ignored while busy.
REQ-007 abort  in  1  synchronous cancel of a running transform.
REQ-008 busy  out  1  transform in progress.
REQ-009 done  out  1  one-cycle pulse when the final write of the final stage has completed.
REQ-010 stage  out  $clog2(N_LOG2)  current stage index.
REQ-011 rd_en  out  1  butterfly operand read strobe.
REQ-012 rd_addr_a, rd_addr_b  out  N_LOG2 each  operand addresses (a = top, b = bottom).
REQ-013 tw_addr  out  N_LOG2-1  twiddle ROM address, valid with rd_en.
REQ-014 wr_en  out  1  result write strobe.
REQ-015 wr_addr_a, wr_addr_b  out  N_LOG2 each  result addresses.

Function
REQ-016 PIPE = 1 + BF_LATENCY (1-cycle memory read + butterfly); a write SHALL occur exactly PIPE cycles after its read.
REQ-017 States: IDLE, ISSUE, DRAIN; IDLE->ISSUE on start, with stage=0 and k=0.
REQ-018 ISSUE: rd_en=1 each cycle, k increments by 1 from 0 to N/2-1; after k=N/2-1, go to DRAIN.
REQ-019 Address rule for stage s, butterfly k: half=2^s, pos=k mod half, a=(k>>s)<<(s+1) | pos, b=a+half, tw=pos<<(N_LOG2-1-s).
REQ-020 DRAIN SHALL last exactly PIPE cycles with rd_en=0, so no next-stage read precedes the final write of the current stage.
REQ-021 DRAIN end: if s<N_LOG2-1, then s increments, k=0, go to ISSUE; else go to IDLE and pulse done in that same cycle.
REQ-022 Per-stage duration SHALL be N/2+PIPE cycles; total start-to-done = N_LOG2*(N/2+PIPE)+1 cycles, counting start as cycle 0.
REQ-023 busy SHALL be 1 in ISSUE and DRAIN and 0 in IDLE; done and busy SHALL never both be 1.
REQ-024 wr_addr_a/b and wr_en SHALL come from a PIPE-deep delay line of rd_addr_a/b and rd_en; no separate address recomputation.
REQ-025 Inputs are in bit-reversed order (DIT); the block SHALL NOT reorder data.
REQ-026 abort in ISSUE or DRAIN: IDLE next cycle; the delay line is flushed so that no wr_en follows; no done pulse.
REQ-027 abort in IDLE is a no-op; abort and start in the same IDLE cycle: abort wins, stays IDLE.
REQ-028 start while busy SHALL be ignored, including in the done cycle (which is already IDLE-bound); start is accepted the cycle after done.

Reset
REQ-029 rst SHALL force IDLE, stage=0, k=0, and clear the delay line asynchronously.
REQ-030 Reset values: busy=0, done=0, rd_en=0, wr_en=0, all addresses=0.
REQ-031 Reset mid-transform SHALL suppress all pending writes; no done pulse follows.

Structure
REQ-032 The state enum and PIPE-related localparam helpers SHALL go in complex_pkg next to the complex type, for reuse by the butterfly and the memory wrapper.
REQ-033 The delay line SHALL be a sub-module, fft_wr_delay, parameterized by depth and width, with async reset.
REQ-034 The address generator SHALL be combinational from (stage, k), inside the top module.

Verification (N_LOG2=3, BF_LATENCY=2, PIPE=3)
REQ-035 Start at cycle 0: rd_en at cycles 1-4 with stage 0 pairs (0,1),(2,3),(4,5),(6,7), tw=0; wr_en at cycles 4-7 with the same pairs.
REQ-036 Stage 1 reads at cycles 8-11 are (0,2)tw0, (1,3)tw2, (4,6)tw0, (5,7)tw2; stage 2 reads at cycles 15-18 are (0,4)tw0, (1,5)tw1, (2,6)tw2, (3,7)tw3.
REQ-037 done is a single pulse at cycle 22, busy is low from cycle 22, and no rd_en occurs during any DRAIN.
REQ-038 abort at cycle 9: IDLE at cycle 10, no wr_en at cycles 10 onward, no done; start at cycle 12 gives a clean run with done at cycle 34.
REQ-039 rst asserted at cycle 5 (mid-write): all outputs 0 immediately, no writes after reset; start held high during busy causes no restart.
